// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder stage reused LSB-first over WIDTH
// cycles, with start/busy/done handshake and registered sum, carry-out and overflow.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   S_IDLE | waiting for start; result registers hold the last result
//   S_RUN  | one operand bit per cycle through the full adder, LSB first
//   S_DONE | one-cycle done pulse; start here chains straight into S_RUN
module serial_add_ctrl #(
   parameter int WIDTH = 8,
   parameter int CW    = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] opa_q, opa_d;
   logic [WIDTH-1:0] opb_q, opb_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;

   logic fa_a, fa_b, fa_su, fa_ca;

   assign fa_a  = opa_q[0];
   assign fa_b  = opb_q[0];
   assign fa_su = fa_a ^ fa_b ^ carry_q;
   assign fa_ca = (fa_a & fa_b) | (fa_a & carry_q) | (fa_b & carry_q);

   always_comb begin
      state_d = state_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               opa_d   = a_in;
               opb_d   = b_in;
               carry_d = cin;
               cnt_d   = '0;
               acc_d   = '0;
               state_d = S_RUN;
            end else begin
               state_d = S_IDLE;
            end
         end

         S_RUN: begin
            acc_d   = {fa_su, acc_q[WIDTH-1:1]};
            opa_d   = {1'b0, opa_q[WIDTH-1:1]};
            opb_d   = {1'b0, opb_q[WIDTH-1:1]};
            carry_d = fa_ca;
            if (cnt_q == CNT_LAST) begin
               // carry_q is the carry into the MSB on this step
               sum_d   = {fa_su, acc_q[WIDTH-1:1]};
               cout_d  = fa_ca;
               ovf_d   = carry_q ^ fa_ca;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         opa_q   <= '0;
         opb_q   <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign busy = (state_q == S_RUN);
   assign done = (state_q == S_DONE);
   assign sum  = sum_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl: stimulus pushes hand-computed results,
// a negedge monitor pops and checks them (including the cycle of done) on each pulse.
module tb_serial_add_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [7:0] a_in = '0;
   logic [7:0] b_in = '0;
   logic       cin = 1'b0;
   logic       busy, done, cout, ovf;
   logic [7:0] sum;

   serial_add_ctrl #(.WIDTH(8), .CW(4)) dut (
      .clk  (clk),
      .rst  (rst),
      .start(start),
      .a_in (a_in),
      .b_in (b_in),
      .cin  (cin),
      .busy (busy),
      .done (done),
      .sum  (sum),
      .cout (cout),
      .ovf  (ovf)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [7:0] sum;
      logic       cout;
      logic       ovf;
      int         cyc;
   } exp_t;

   exp_t sb[$];
   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every done pulse must match the oldest expected result and its cycle.
   always @(negedge clk) begin
      if (done === 1'b1) begin
         if (sb.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL spurious_done: got done=1, expected no pending result (cycle %0d)", cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("sum", {24'd0, sum}, {24'd0, e.sum});
            chk("cout", {31'd0, cout}, {31'd0, e.cout});
            chk("ovf", {31'd0, ovf}, {31'd0, e.ovf});
            chk("done_cycle", cyc, e.cyc);
         end
      end
   end

   // Called at a negedge; start is seen at the next edge, done 9 negedges later.
   task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic c,
                        input logic [7:0] es, input logic ec, input logic eo);
      a_in  = a;
      b_in  = b;
      cin   = c;
      start = 1'b1;
      sb.push_back('{es, ec, eo, cyc + 9});
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 40; i++) begin
         if (sb.size() == 0) break;
         @(negedge clk);
      end
      if (sb.size() != 0) begin
         n_vec++;
         n_bad++;
         $display("FAIL timeout: got %0d pending results, expected 0 (cycle %0d)", sb.size(), cyc);
         sb.delete();
      end
      @(negedge clk);
   endtask

   task automatic chk_idle_outputs(input logic [7:0] exp_sum);
      chk("busy", {31'd0, busy}, 32'd0);
      chk("done", {31'd0, done}, 32'd0);
      chk("sum_idle", {24'd0, sum}, {24'd0, exp_sum});
      chk("cout_idle", {31'd0, cout}, 32'd0);
      chk("ovf_idle", {31'd0, ovf}, 32'd0);
   endtask

   int nb;

   initial begin
      // reset, then idle with start low
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk_idle_outputs(8'h00);
         @(negedge clk);
      end

      // 0x5A + 0x3C: busy for exactly 8 cycles, signed overflow
      issue(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1);
      nb = 0;
      for (int i = 0; i < 9; i++) begin
         if (busy === 1'b1) nb++;
         @(negedge clk);
      end
      chk("busy_cycles", nb, 32'd8);
      wait_idle();

      issue(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
      wait_idle();
      issue(8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1);
      wait_idle();
      issue(8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0);
      wait_idle();

      // start held high: back-to-back runs 9 cycles apart, no restart mid-RUN
      a_in  = 8'h10;
      b_in  = 8'h20;
      cin   = 1'b0;
      start = 1'b1;
      sb.push_back('{8'h30, 1'b0, 1'b0, cyc + 9});
      @(negedge clk);
      a_in = 8'h01;
      b_in = 8'h01;
      sb.push_back('{8'h02, 1'b0, 1'b0, cyc + 17});
      repeat (17) @(negedge clk);
      start = 1'b0;
      wait_idle();
      chk("sum_held", {24'd0, sum}, 32'h02);

      // operand change and start pulse mid-RUN are ignored
      issue(8'h33, 8'h44, 1'b1, 8'h78, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      a_in  = 8'hFF;
      b_in  = 8'hFF;
      cin   = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_idle();

      // reset in the middle of a RUN discards the partial result
      issue(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0);
      wait_idle();
      chk("sum_before_rst", {24'd0, sum}, 32'h30);
      issue(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      sb.delete();
      chk_idle_outputs(8'h00);
      rst = 1'b0;
      for (int i = 0; i < 12; i++) begin
         chk("no_done_after_rst", {31'd0, done}, 32'd0);
         @(negedge clk);
      end

      issue(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
      wait_idle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial adder controller. Sequences one 1-bit full-adder stage (su = a^b^c, ca = majority(a,b,c)) over WIDTH cycles to add two WIDTH-bit operands.
- Trades latency for area in the arithmetic datapath; the stage is reused once per bit, LSB first.
- Provides a start/busy/done handshake, a registered result, carry-out and signed overflow.

Parameters:
- WIDTH, 8: operand/result width in bits (≥2).
- CW, 4: bit-counter width; must satisfy 2^CW > WIDTH-1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start  input  1  request a new addition; sampled only in IDLE or DONE
- a_in  input  WIDTH  operand A, captured on accepted start
- b_in  input  WIDTH  operand B, captured on accepted start
- cin  input  1  carry-in, captured on accepted start
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse, result valid
- sum  output  WIDTH  registered result, held until next completion
- cout  output  1  carry out of MSB, held with sum
- ovf  output  1  signed overflow (carry into MSB XOR carry out of MSB), held with sum

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE; busy, done, sum, cout, ovf, counter, carry register and shift registers all 0.
  - Reset overrides everything, including mid-RUN; the partial result is discarded and sum is not updated.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge → load opA<=a_in, opB<=b_in, carry<=cin, cnt<=0, acc<=0; go to RUN.
  - start=0 → stay in IDLE.
- RUN, every edge:
  - FA inputs: opA[0], opB[0], carry.
  - acc <= {su, acc[WIDTH-1:1]} (result bit shifts in at the MSB).
  - opA and opB shift right by one, zero-filled.
  - carry <= ca.
  - When cnt==WIDTH-1 (MSB step), also capture carry_in_msb <= carry.
  - cnt increments.
- RUN exit: at the edge where cnt==WIDTH-1, go to DONE and load:
  - sum <= {su, acc[WIDTH-1:1]}
  - cout <= ca
  - ovf <= carry ^ ca
  - done <= 1
- DONE:
  - Lasts exactly one cycle; done=1 only in this cycle.
  - start=1 at the next edge → accepted as in IDLE; back-to-back operation with no IDLE gap.
  - Otherwise go to IDLE.
  - done falls on that edge either way.
- busy=1 exactly while state==RUN (registered, asserted the cycle after the accepting edge).
- Latency:
  - start accepted at edge E0 → RUN for WIDTH edges (E1..E_WIDTH).
  - done high in the cycle after E_WIDTH.
  - Total WIDTH+1 edges from start to done.
- start while busy (RUN) is ignored. Input operand changes during RUN have no effect.
- sum/cout/ovf change only at the RUN→DONE edge or on reset; stable otherwise.
- The counter never wraps: it is reset to 0 on each accepted start and stops at WIDTH-1.
- Arithmetic is modulo 2^WIDTH; cout is the unsigned carry, ovf the two's-complement overflow.

Test Plan:
- Reset then idle, WIDTH=8: rst high 2 cycles, start=0 → busy=0, done=0, sum=0x00, cout=0, ovf=0 indefinitely.
- a_in=0x5A, b_in=0x3C, cin=0, start pulse → busy high 8 cycles; done pulses 9 edges after start with sum=0x96, cout=0, ovf=1.
- a_in=0xFF, b_in=0x01, cin=0 → sum=0x00, cout=1, ovf=0. Then a_in=0x7F, b_in=0x00, cin=1 → sum=0x80, cout=0, ovf=1.
- start held high continuously with operands 0x10+0x20 then 0x01+0x01:
  - Results 0x30 then 0x02.
  - Second RUN begins the edge after done; done pulses exactly every 9 cycles.
  - start during RUN does not restart.
- Change a_in/b_in and pulse start mid-RUN → ignored; result matches operands captured at acceptance.
- Assert rst at cycle 4 of RUN (previous sum=0x30) → next cycle: busy=0, sum=0x00, no done pulse. A new start then completes normally.
